block_dispatcher: RTL
=====================

Name: block_dispatcher

Overview:
Sequences kernel execution across the compute cores. On start it latches the thread count held by the device control register and splits it into blocks of THREADS_PER_BLOCK threads. It hands blocks to free cores one per cycle, recycles each core with a one-cycle reset between blocks, and raises done once every block has retired.

Parameters:
NUM_CORES, 2, number of compute cores managed (1..8)
THREADS_PER_BLOCK, 4, max threads per block (power of two, 1..128)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  launch kernel; sampled only in IDLE
thread_count  input  8  total threads, from device control register
core_done  input  NUM_CORES  per-core level: assigned block finished
core_start  output  NUM_CORES  per-core level: block assigned, execute
core_reset  output  NUM_CORES  per-core reset request
core_block_id  output  8*NUM_CORES  block index for core i at bits [8i+7:8i]
core_thread_count  output  (clog2(TPB)+1)*NUM_CORES  threads in core i's block, packed the same way
done  output  1  kernel complete

Behaviour:
- Reset is synchronous, active-high; clock is clk. Reset values: state IDLE, core_start=0, core_reset=all 1s, core_block_id=0, core_thread_count=0, done=0, all counters 0.
- All outputs are registered.
- Top FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - core_reset is held all 1s.
  - On start=1: latch tc=thread_count and total_blocks=ceil(tc/TPB), computed with 9-bit intermediate, result fits 8 bits.
  - Clear dispatched and retired counters, then go to RUN.
  - If tc=0, go directly to DONE instead.
- RUN, first cycle: core_reset=0 and all core slots are FREE.
- Per-core slot states: FREE, BUSY.
- Dispatch, at most one per cycle:
  - At a clock edge in RUN, if dispatched<total_blocks and any slot is FREE, pick the lowest-index FREE core k.
  - Next cycle: core_start[k]=1, core_reset[k]=0, core_block_id[k]=dispatched, core_thread_count[k]=min(TPB, tc − dispatched*TPB). Then dispatched++ and slot k becomes BUSY.
- Completion:
  - A BUSY core i with core_done[i]=1 at an edge gets core_start[i]=0 and core_reset[i]=1 next cycle. Its slot becomes FREE and retired increases.
  - Multiple completions in one cycle add popcount to retired.
  - core_done on a FREE core is ignored.
- Re-dispatch to a freed core happens no earlier than the edge ending its core_reset cycle. core_reset therefore pulses exactly one cycle between consecutive blocks on a core.
- A freed core with no remaining blocks keeps core_reset=1.
- Completion and dispatch of different cores may occur in the same cycle.
- Latency: start sampled at edge T gives RUN at T+1 and first core_start at T+2.
- Termination:
  - When retired reaches total_blocks at an edge, enter DONE. done=1 from the next cycle.
  - In DONE: core_start=0, core_reset=all 1s. DONE is exited only by reset; start is ignored.
- thread_count is latched at start; changes during RUN or DONE have no effect.
- start outside IDLE is ignored.
- Reset asserted mid-RUN: all outputs return to reset values on the next edge and in-flight blocks are abandoned. A subsequent start restarts from block 0.

Test Plan:
- NUM_CORES=2, TPB=4, thread_count=10, start pulse; each core asserts core_done 5 cycles after its core_start rises -> blocks 0,1 go to cores 0,1 with count 4. After core 0 retires, core_reset[0] pulses one cycle, then block 2 goes to core 0 with count 2. done=1 the cycle after the third retirement.
- thread_count=0, start -> done=1 two cycles after start; core_start stays 0 throughout.
- thread_count=8; both cores raise core_done in the same cycle -> retired jumps 0→2 in one edge and done=1 the next cycle.
- thread_count=4 -> exactly one dispatch: block 0 with count 4 to core 0. core_start[1] never rises; done after core 0 retires.
- thread_count=20 with 2 cores; assert reset during RUN after 2 dispatches -> all outputs at reset values next cycle. A new start with thread_count=5 dispatches block 0 (count 4) and block 1 (count 1).
- thread_count=10, start, then drive thread_count=200 during RUN -> exactly 3 blocks dispatched. start pulses in RUN and DONE are ignored; done stays 1 until reset.

Source files
------------

// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: splits a latched thread count into blocks and hands them
// to free cores one per cycle, recycling each core through a one-cycle reset.
//   state  | meaning
//   S_IDLE | cores held in reset, waiting for start
//   S_RUN  | dispatching blocks and retiring completions
//   S_DONE | every block retired; held until reset
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [7:0]                                            thread_count,
  input  logic [NUM_CORES-1:0]                                  core_done,
  output logic [NUM_CORES-1:0]                                  core_start,
  output logic [NUM_CORES-1:0]                                  core_reset,
  output logic [8*NUM_CORES-1:0]                                core_block_id,
  output logic [($clog2(THREADS_PER_BLOCK)+1)*NUM_CORES-1:0]    core_thread_count,
  output logic                                                  done
);

  localparam int              SH    = $clog2(THREADS_PER_BLOCK);
  localparam int              CW    = SH + 1;
  localparam logic [7:0]      TPB_B = 8'(THREADS_PER_BLOCK);
  localparam logic [CW-1:0]   TPB_C = CW'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_n;
  logic [7:0]              total_q, total_n;
  logic [7:0]              disp_q, disp_n;
  logic [7:0]              ret_q, ret_n;
  logic [7:0]              rem_q, rem_n;
  logic [NUM_CORES-1:0]    busy_q, busy_n;
  logic [NUM_CORES-1:0]    start_n, reset_n;
  logic [8*NUM_CORES-1:0]  id_n;
  logic [CW*NUM_CORES-1:0] cnt_n;
  logic                    done_n;

  logic [NUM_CORES-1:0]    fin;
  logic [7:0]              fin_cnt;
  logic [2:0]              pick;
  logic                    have_free;
  logic [CW-1:0]           blk_cnt;
  logic                    can_disp;

  // A core freed at this edge is still marked busy, so it cannot be re-picked
  // until the edge that ends its one-cycle reset.
  always_comb begin
    fin       = core_done & busy_q;
    fin_cnt   = '0;
    pick      = '0;
    have_free = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      fin_cnt = fin_cnt + {7'd0, fin[i]};
      if (!busy_q[i]) begin
        pick      = 3'(i);
        have_free = 1'b1;
      end
    end
    blk_cnt  = (rem_q >= TPB_B) ? TPB_C : rem_q[CW-1:0];
    can_disp = (state_q == S_RUN) && have_free && (disp_q < total_q);
  end

  always_comb begin
    state_n = state_q;
    total_n = total_q;
    disp_n  = disp_q;
    ret_n   = ret_q;
    rem_n   = rem_q;
    busy_n  = busy_q;
    start_n = core_start;
    reset_n = core_reset;
    id_n    = core_block_id;
    cnt_n   = core_thread_count;
    done_n  = done;
    unique case (state_q)
      S_IDLE: begin
        start_n = '0;
        reset_n = '1;
        done_n  = 1'b0;
        if (start) begin
          total_n = 8'(({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> SH);
          rem_n   = thread_count;
          disp_n  = '0;
          ret_n   = '0;
          busy_n  = '0;
          if (thread_count == 8'd0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_RUN;
            reset_n = '0;
          end
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (fin[i]) begin
            busy_n[i]  = 1'b0;
            start_n[i] = 1'b0;
            reset_n[i] = 1'b1;
          end
        end
        ret_n = ret_q + fin_cnt;
        if (can_disp) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (pick == 3'(i)) begin
              busy_n[i]           = 1'b1;
              start_n[i]          = 1'b1;
              reset_n[i]          = 1'b0;
              id_n[8*i +: 8]      = disp_q;
              cnt_n[CW*i +: CW]   = blk_cnt;
            end
          end
          disp_n = disp_q + 8'd1;
          rem_n  = rem_q - 8'(blk_cnt);
        end
        if (ret_n == total_q) begin
          state_n = S_DONE;
          start_n = '0;
          reset_n = '1;
        end
      end
      S_DONE: begin
        start_n = '0;
        reset_n = '1;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      total_q           <= '0;
      disp_q            <= '0;
      ret_q             <= '0;
      rem_q             <= '0;
      busy_q            <= '0;
      core_start        <= '0;
      core_reset        <= '1;
      core_block_id     <= '0;
      core_thread_count <= '0;
      done              <= 1'b0;
    end else begin
      state_q           <= state_n;
      total_q           <= total_n;
      disp_q            <= disp_n;
      ret_q             <= ret_n;
      rem_q             <= rem_n;
      busy_q            <= busy_n;
      core_start        <= start_n;
      core_reset        <= reset_n;
      core_block_id     <= id_n;
      core_thread_count <= cnt_n;
      done              <= done_n;
    end
  end

endmodule
